// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: R-type funct codes,
// controller state encoding and a small funct-decode helper.
package mdu_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // True for the four functs that start an iterative operation.
  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  // True for the two functs that take the signed path.
  function automatic logic is_signed_op(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

  // True for the two divide functs.
  function automatic logic is_div_op(input logic [5:0] funct);
    return (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit / execute stage
// (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [5:0]       Function_opcode;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, Function_opcode, Read_data_1, Read_data_2,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, Function_opcode, Read_data_1, Read_data_2,
    output busy, done, HI, LO
  );

endinterface

// File: rtl/mdu_step.sv
// One combinational iteration of the shared accumulator datapath.
//  Multiply: shift-add. If the accumulator LSB (current multiplier bit) is
//            set, the operand is added into the upper half, then the whole
//            accumulator including the carry shifts right by one.
//  Divide:   restoring shift-subtract. The partial remainder (upper half)
//            shifts left taking in the next dividend bit; if it is not less
//            than the divisor the divisor is subtracted and a 1 quotient bit
//            enters at the LSB.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // Single add-shift or subtract-shift step.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    acc_next  = '0;
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff      = rem_shift - {1'b0, operand};
    if (is_div) begin
      // diff[WIDTH] is the borrow: set means the remainder was too small.
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers. Operands are
// converted to magnitudes at start, WIDTH iterations run one bit per cycle,
// and a final FIX cycle applies sign correction and writes HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clock,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state;
  state_e             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

  logic               accept;
  logic               mt_hi;
  logic               mt_lo;
  logic               calc_en;
  logic               fix_en;
  logic               busy_int;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand;
  logic               op_div;
  logic               neg_main;
  logic               neg_rem;
  logic               div_zero;

  logic               start_signed;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_new;
  logic [WIDTH-1:0]   lo_new;

  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> CALC for WIDTH cycles -> FIX -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:                    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Output/strobe decode; requests are only honoured while idle.
  always_comb begin
    busy_int = (state != IDLE);
    accept   = 1'b0;
    mt_hi    = 1'b0;
    mt_lo    = 1'b0;
    calc_en  = 1'b0;
    fix_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = is_muldiv(bus.Function_opcode);
          mt_hi  = (bus.Function_opcode == FUNCT_MTHI);
          mt_lo  = (bus.Function_opcode == FUNCT_MTLO);
        end
      end
      CALC:    calc_en = 1'b1;
      FIX:     fix_en  = 1'b1;
      default: ;
    endcase
  end

  // Operand sign extraction and magnitudes, only meaningful for signed ops.
  always_comb begin
    start_signed = is_signed_op(bus.Function_opcode);
    sign_a       = start_signed & bus.Read_data_1[WIDTH-1];
    sign_b       = start_signed & bus.Read_data_2[WIDTH-1];
    mag_a        = sign_a ? -bus.Read_data_1 : bus.Read_data_1;
    mag_b        = sign_b ? -bus.Read_data_2 : bus.Read_data_2;
  end

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (op_div),
    .acc_next (acc_step)
  );

  // Sign correction of the finished accumulator. For a zero divisor the
  // remainder path already reproduces the latched dividend; only the
  // quotient needs forcing to all ones.
  always_comb begin
    prod_fix = neg_main ? -acc : acc;
    quo_fix  = div_zero ? '1 : (neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_new   = op_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    lo_new   = op_div ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // Iteration counter: cleared on accept, counts CALC cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (calc_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Datapath registers: load operands on accept, step during CALC.
  always_ff @(posedge clock) begin
    // NOTE: these registers are deliberately not reset; they are always
    // reloaded on accept before use, and the FSM ignores them while idle.
    if (accept) begin
      op_div   <= is_div_op(bus.Function_opcode);
      neg_main <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= (bus.Read_data_2 == '0);
      if (is_div_op(bus.Function_opcode)) begin
        acc     <= {{WIDTH{1'b0}}, mag_a};
        operand <= mag_b;
      end else begin
        acc     <= {{WIDTH{1'b0}}, mag_b};
        operand <= mag_a;
      end
    end else if (calc_en) begin
      acc <= acc_step;
    end
  end

  // HI/LO and the done pulse: written only by FIX or MTHI/MTLO.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix_en;
      if (fix_en) begin
        hi_q <= hi_new;
        lo_q <= lo_new;
      end else begin
        if (mt_hi) hi_q <= bus.Read_data_1;
        if (mt_lo) lo_q <= bus.Read_data_1;
      end
    end
  end

  assign bus.busy = busy_int;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO pairs,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;

  exp_t exp_q[$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.done !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_hi"}, 64'(bus.HI), 64'(e.hi));
          check({e.name, "_lo"}, 64'(bus.LO), 64'(e.lo));
          check({e.name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present a request for one cycle, then scramble the operand inputs.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    bus.start           = 1'b1;
    bus.Function_opcode = f;
    bus.Read_data_1     = a;
    bus.Read_data_2     = b;
    @(negedge clock);
    bus.start       = 1'b0;
    bus.Read_data_1 = $urandom;
    bus.Read_data_2 = $urandom;
  endtask

  // Count negedges with busy high, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clock);
    end
    if (cycles >= 200) check("busy_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_t e;
    int   cyc;
    e.hi = hi; e.lo = lo; e.name = name;
    exp_q.push_back(e);
    issue(f, a, b);
    wait_idle(cyc);
    check({name, "_busy_cycles"}, 64'(cyc), 64'(W + 1));
  endtask

  initial begin
    int cyc;
    exp_t e;
    bus.start           = 1'b0;
    bus.Function_opcode = '0;
    bus.Read_data_1     = '0;
    bus.Read_data_2     = '0;
    repeat (2) @(negedge clock);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi",   64'(bus.HI),   64'd0);
    check("reset_lo",   64'(bus.LO),   64'd0);
    reset = 1'b0;

    run_op("mult_neg3x7",   FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max",     FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_minxmin",  FUNCT_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg7_2",    FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_neg7_2",   FUNCT_DIVU,  32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_7_neg2",    FUNCT_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_min_neg1",  FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_by_zero",  FUNCT_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_neg_by_0",  FUNCT_DIV,   32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // MTHI then MTLO on consecutive idle cycles.
    @(negedge clock);
    bus.start = 1'b1; bus.Function_opcode = FUNCT_MTHI; bus.Read_data_1 = 32'hA5A5_A5A5;
    @(negedge clock);
    check("mthi_hi",   64'(bus.HI),   64'hA5A5_A5A5);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check("mthi_done", 64'(bus.done), 64'd0);
    bus.Function_opcode = FUNCT_MTLO; bus.Read_data_1 = 32'h5A5A_5A5A;
    @(negedge clock);
    bus.start = 1'b0;
    check("mtlo_lo",   64'(bus.LO),   64'h5A5A_5A5A);
    check("mtlo_hi",   64'(bus.HI),   64'hA5A5_A5A5);
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    check("mtlo_done", 64'(bus.done), 64'd0);

    // A second start during a running DIV must be ignored.
    e.hi = 32'h0000_0002; e.lo = 32'hFFFF_FFF2; e.name = "div_100_neg7";
    exp_q.push_back(e);
    issue(FUNCT_DIV, 32'd100, 32'hFFFF_FFF9);
    repeat (4) @(negedge clock);
    bus.start = 1'b1; bus.Function_opcode = FUNCT_MULT;
    bus.Read_data_1 = 32'd3; bus.Read_data_2 = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    wait_idle(cyc);
    repeat (3) @(negedge clock);
    check("ignored_start_busy", 64'(bus.busy), 64'd0);

    // Reset during CALC iteration 10 of a MULT aborts without a result.
    issue(FUNCT_MTHI, 32'h0000_0011, 32'd0);
    check("pre_abort_hi", 64'(bus.HI), 64'h11);
    issue(FUNCT_MULT, 32'd5, 32'd9);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi",   64'(bus.HI),   64'd0);
    check("abort_lo",   64'(bus.LO),   64'd0);
    repeat (40) @(negedge clock);
    check("abort_still_idle", 64'(bus.busy), 64'd0);
    run_op("mult_6x7", FUNCT_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit that sits beside the single-cycle ALU in the execute stage and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiply and divide are iterative, one bit per cycle, and parametrised in data width.
- Reports busy so the control unit stalls the pipeline. MFHI/MFLO read the HI/LO outputs directly.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits (even, ≥4).
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, not overridden.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only while idle.
- Function_opcode  input  6  R-type funct: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO.
- Read_data_1  input  WIDTH  rs operand: multiplicand/dividend, or source for MTHI/MTLO.
- Read_data_2  input  WIDTH  rt operand: multiplier/divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO have taken a new multiply/divide result.
- HI  output  WIDTH  HI register: product upper half, or remainder.
- LO  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0.
- Reset dominates everything, including an operation in progress: it aborts immediately and does not update HI/LO with a partial result.
- States:
  - IDLE: start with a mul/div funct latches the operands and op, and computes operand magnitudes for signed ops → CALC, counter=0. start with MTHI/MTLO writes Read_data_1 into HI/LO at that edge and stays in IDLE, with no busy and no done. Any other funct with start is ignored.
  - CALC: one iteration per cycle, counter increments; after WIDTH iterations → FIX.
    - Multiply: shift-add on a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract; remainder in the upper half, quotient in the lower half.
  - FIX: applies sign correction, writes HI/LO, sets done=1 for the next cycle → IDLE.
- Latency: start sampled at edge t.
  - busy=1 from after edge t until after edge t+WIDTH+1.
  - HI/LO are updated at edge t+WIDTH+1.
  - done=1 for exactly the cycle following that edge; busy=0 in the same cycle.
- busy = (state != IDLE). start while busy is ignored, not queued. The control unit must hold the instruction until busy=0.
- Signed multiply: result is the product of magnitudes, negated in 2·WIDTH bits if the operand signs differ.
- Signed divide:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Quotient truncates toward zero.
- Unsigned ops: no sign handling.
- Most-negative dividend / −1 (signed): LO=100…0, HI=0. No exception.
- Divide by zero, signed or unsigned: LO=all ones, HI=Read_data_1 as latched. Takes the full latency, no exception.
- Operands are latched at start; later changes to Read_data_1/2 have no effect.
- HI/LO hold their value in every cycle except the FIX write and the MTHI/MTLO write.

Decomposition:
- Package mdu_pkg holds:
  - funct constants FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO;
  - state enum {IDLE, CALC, FIX}.
- Optional sub-module mdu_step: the combinational single iteration (add-shift or subtract-shift), parametrised by WIDTH. The FSM, counter and HI/LO registers stay in mult_div_unit.

Test Plan:
- MULT, WIDTH=32, rs=0xFFFFFFFD (−3), rt=7 → done at edge t+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with the same operands → LO=0x7FFFFFFC, HI=1.
- DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU rs=0x1234, rt=0 → LO=0xFFFFFFFF, HI=0x1234.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A on consecutive idle cycles → HI/LO update at each edge; busy and done stay 0. A second start (MULT) during a running DIV is ignored, and the result equals the DIV result.
- Reset asserted at CALC iteration 10 of a MULT after HI=0x11 → next cycle busy=0, done=0, HI=LO=0. No done pulse follows. A new MULT 6×7 then gives LO=42, HI=0.
